// File: rtl/check_sequencer_if.sv
// rtl/check_sequencer_if.sv - load, candidate, checker and status signals of check_sequencer
interface check_sequencer_if;
  logic         load_valid;
  logic [127:0] load_hash;
  logic         load_ready;
  logic         cand_valid;
  logic [127:0] cand_hash;
  logic [31:0]  cand_tag;
  logic         cand_ready;
  logic         newrdy;
  logic         checkrdy;
  logic [127:0] hash;
  logic         resultrdy;
  logic         matchfound;
  logic         hit_valid;
  logic [31:0]  hit_tag;
  logic [127:0] hit_hash;
  logic [6:0]   targets_loaded;
  logic [31:0]  checked_count;
  logic         busy;
  logic         error;

  modport slave (
    input  load_valid, load_hash, cand_valid, cand_hash, cand_tag, resultrdy, matchfound,
    output load_ready, cand_ready, newrdy, checkrdy, hash, hit_valid, hit_tag, hit_hash,
           targets_loaded, checked_count, busy, error
  );

  modport master (
    output load_valid, load_hash, cand_valid, cand_hash, cand_tag, resultrdy, matchfound,
    input  load_ready, cand_ready, newrdy, checkrdy, hash, hit_valid, hit_tag, hit_hash,
           targets_loaded, checked_count, busy, error
  );
endinterface

// File: rtl/check_sequencer.sv
// rtl/check_sequencer.sv - feeds target loads and queued candidates to an external hash checker
module check_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_TARGETS = 64,
  parameter int TIMEOUT     = 16
) (
  input logic               clk,
  input logic               nrst,
  check_sequencer_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_NEW, S_WAIT_NEW, S_ISSUE_CHK, S_WAIT_CHK, S_DRAIN, S_ERROR
  } state_t;

  state_t           r_state, w_next;
  logic [127:0]     r_fifo_hash [FIFO_DEPTH];
  logic [31:0]      r_fifo_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_fifo_cnt;
  logic [127:0]     r_hash, r_hit_hash;
  logic [31:0]      r_tag, r_hit_tag, r_checked;
  logic             r_hit_valid;
  logic [6:0]       r_targets;
  logic [TMO_W-1:0] r_wait_cnt;

  logic w_full, w_empty, w_error, w_load_ready, w_cand_ready;
  logic w_load_acc, w_push, w_pop, w_timeout, w_waiting;
  logic w_newrdy, w_checkrdy, w_busy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full       = (r_fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_fifo_cnt == '0);
  assign w_error      = (r_state == S_ERROR);
  // Ready outputs are gated by nrst so they read low for the whole reset pulse.
  assign w_load_ready = nrst && (r_state == S_IDLE) && (r_targets < 7'(MAX_TARGETS)) && !w_error;
  assign w_cand_ready = nrst && !w_full && !w_error;
  assign w_load_acc   = bus.load_valid && w_load_ready;
  assign w_push       = bus.cand_valid && w_cand_ready;
  assign w_pop        = (r_state == S_IDLE) && !w_load_acc && !w_empty && (r_targets != '0);
  assign w_waiting    = (r_state == S_WAIT_NEW) || (r_state == S_WAIT_CHK);
  assign w_timeout    = (r_wait_cnt == TMO_W'(TIMEOUT - 1));

  always_comb begin
    w_next     = r_state;
    w_newrdy   = 1'b0;
    w_checkrdy = 1'b0;
    w_busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_load_acc)  w_next = S_ISSUE_NEW;
        else if (w_pop)  w_next = S_ISSUE_CHK;
      end
      S_ISSUE_NEW: begin
        w_newrdy = 1'b1;
        w_next   = S_WAIT_NEW;
      end
      S_ISSUE_CHK: begin
        w_checkrdy = 1'b1;
        w_next     = S_WAIT_CHK;
      end
      S_WAIT_NEW, S_WAIT_CHK: begin
        if (bus.resultrdy)  w_next = S_DRAIN;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_DRAIN: begin
        if (!bus.resultrdy) w_next = S_IDLE;
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_hash[r_wr_ptr] <= bus.cand_hash;
      r_fifo_tag[r_wr_ptr]  <= bus.cand_tag;
    end
  end

  // hash only changes from IDLE, so it is stable through ISSUE/WAIT/DRAIN.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hash      <= '0;
      r_tag       <= '0;
      r_hit_valid <= 1'b0;
      r_hit_tag   <= '0;
      r_hit_hash  <= '0;
      r_targets   <= '0;
      r_checked   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_hit_valid <= 1'b0;
      r_wait_cnt  <= w_waiting ? r_wait_cnt + 1'b1 : '0;
      if (w_load_acc) begin
        r_hash <= bus.load_hash;
      end else if (w_pop) begin
        r_hash <= r_fifo_hash[r_rd_ptr];
        r_tag  <= r_fifo_tag[r_rd_ptr];
      end
      if ((r_state == S_WAIT_NEW) && bus.resultrdy) r_targets <= r_targets + 7'd1;
      if ((r_state == S_WAIT_CHK) && bus.resultrdy) begin
        r_checked <= r_checked + 32'd1;
        if (bus.matchfound) begin
          r_hit_valid <= 1'b1;
          r_hit_tag   <= r_tag;
          r_hit_hash  <= r_hash;
        end
      end
    end
  end

  assign bus.load_ready     = w_load_ready;
  assign bus.cand_ready     = w_cand_ready;
  assign bus.newrdy         = w_newrdy;
  assign bus.checkrdy       = w_checkrdy;
  assign bus.hash           = r_hash;
  assign bus.hit_valid      = r_hit_valid;
  assign bus.hit_tag        = r_hit_tag;
  assign bus.hit_hash       = r_hit_hash;
  assign bus.targets_loaded = r_targets;
  assign bus.checked_count  = r_checked;
  assign bus.busy           = w_busy;
  assign bus.error          = w_error;
endmodule

// File: tb/tb_check_sequencer.sv
// tb/tb_check_sequencer.sv - directed bench for check_sequencer with a behavioural hash checker
module tb_check_sequencer;
  localparam logic [127:0] H11 = {16{8'h11}};
  localparam logic [127:0] H22 = {16{8'h22}};
  localparam logic [127:0] H33 = {16{8'h33}};
  localparam logic [127:0] H44 = {16{8'h44}};
  localparam logic [127:0] H55 = {16{8'h55}};
  localparam logic [127:0] H66 = {16{8'h66}};
  localparam logic [127:0] H77 = {16{8'h77}};

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  check_sequencer_if bus();

  check_sequencer #(.FIFO_DEPTH(4), .MAX_TARGETS(64), .TIMEOUT(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic rsp_en = 1'b1;
  logic rsp_is_new;
  logic [127:0] rsp_h;
  logic [127:0] tgt_q[$];
  int hit_cnt = 0, new_cnt = 0, chk_cnt = 0, both_cnt = 0;
  int t_chk = -1, t_hit = -1, t_idle = -1;
  logic prev_busy = 1'b0;
  logic [127:0] chk_hash_q[$];
  int   ev_cyc_q[$];
  logic ev_new_q[$];

  task automatic expect_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic model_has(input logic [127:0] h);
    foreach (tgt_q[i]) if (tgt_q[i] == h) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.newrdy) begin
      new_cnt++;
      ev_cyc_q.push_back(cyc);
      ev_new_q.push_back(1'b1);
    end
    if (bus.checkrdy) begin
      chk_cnt++;
      t_chk = cyc;
      chk_hash_q.push_back(bus.hash);
      ev_cyc_q.push_back(cyc);
      ev_new_q.push_back(1'b0);
    end
    if (bus.newrdy && bus.checkrdy) both_cnt++;
    if (bus.hit_valid) begin
      hit_cnt++;
      t_hit = cyc;
    end
    if (prev_busy && !bus.busy) t_idle = cyc;
    prev_busy = bus.busy;
  end

  // Checker: resultrdy rises 4 cycles after the request and stays high 2 cycles.
  initial begin
    bus.resultrdy  = 1'b0;
    bus.matchfound = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_en && nrst && (bus.newrdy || bus.checkrdy)) begin
        rsp_is_new = bus.newrdy;
        rsp_h      = bus.hash;
        repeat (4) @(negedge clk);
        bus.matchfound = rsp_is_new ? 1'b0 : model_has(rsp_h);
        if (rsp_is_new) tgt_q.push_back(rsp_h);
        bus.resultrdy = 1'b1;
        repeat (2) @(negedge clk);
        bus.resultrdy  = 1'b0;
        bus.matchfound = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    bus.load_valid = 1'b0;
    bus.cand_valid = 1'b0;
    repeat (8) @(negedge clk);
    tgt_q.delete();
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_tgt(input logic [127:0] h);
    int n = 0;
    bus.load_valid = 1'b1;
    bus.load_hash  = h;
    while (!bus.load_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    expect_eq("load_ready_seen", bus.load_ready, 1'b1);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic push_cand(input logic [127:0] h, input logic [31:0] tag);
    int n = 0;
    bus.cand_valid = 1'b1;
    bus.cand_hash  = h;
    bus.cand_tag   = tag;
    while (!bus.cand_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    expect_eq("cand_ready_seen", bus.cand_ready, 1'b1);
    @(negedge clk);
    bus.cand_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      q = bus.busy ? 0 : q + 1;
    end
    expect_eq("quiet", bus.busy, 1'b0);
  endtask

  task automatic wait_chk(output int t);
    int n = 0;
    while (!bus.checkrdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    expect_eq("checkrdy_seen", bus.checkrdy, 1'b1);
    t = cyc;
  endtask

  initial begin
    int h0, n0, t;
    nrst = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_hash  = '0;
    bus.cand_valid = 1'b0;
    bus.cand_hash  = '0;
    bus.cand_tag   = '0;
    repeat (3) @(negedge clk);
    expect_eq("rst_busy", bus.busy, 1'b0);
    expect_eq("rst_error", bus.error, 1'b0);
    expect_eq("rst_newrdy", bus.newrdy, 1'b0);
    expect_eq("rst_checkrdy", bus.checkrdy, 1'b0);
    expect_eq("rst_hit_valid", bus.hit_valid, 1'b0);
    expect_eq("rst_load_ready", bus.load_ready, 1'b0);
    expect_eq("rst_targets", bus.targets_loaded, 7'd0);
    expect_eq("rst_checked", bus.checked_count, 32'd0);
    expect_eq("rst_hash", bus.hash, 128'd0);
    expect_eq("rst_hit_tag", bus.hit_tag, 32'd0);
    expect_eq("rst_hit_hash", bus.hit_hash, 128'd0);
    nrst = 1'b1;
    @(negedge clk);
    expect_eq("post_rst_cand_ready", bus.cand_ready, 1'b1);
    expect_eq("post_rst_load_ready", bus.load_ready, 1'b1);

    // Two targets, then a matching candidate
    load_tgt(H11);
    wait_quiet();
    load_tgt(H22);
    wait_quiet();
    expect_eq("two_targets", bus.targets_loaded, 7'd2);
    h0 = hit_cnt;
    push_cand(H22, 32'd7);
    wait_quiet();
    expect_eq("match_hit_pulses", hit_cnt - h0, 1);
    expect_eq("match_hit_tag", bus.hit_tag, 32'd7);
    expect_eq("match_hit_hash", bus.hit_hash, H22);
    expect_eq("match_checked", bus.checked_count, 32'd1);
    expect_eq("lat_hit_after_chk", t_hit - t_chk, 5);
    expect_eq("lat_idle_after_chk", t_idle - t_chk, 7);

    // Non-matching candidate
    h0 = hit_cnt;
    push_cand(H33, 32'd9);
    wait_quiet();
    expect_eq("miss_hit_pulses", hit_cnt - h0, 0);
    expect_eq("miss_checked", bus.checked_count, 32'd2);
    expect_eq("miss_busy", bus.busy, 1'b0);
    expect_eq("miss_hit_tag_held", bus.hit_tag, 32'd7);

    // Back-to-back candidates: second push coincides with the first pop
    h0 = hit_cnt;
    push_cand(H44, 32'd8);
    push_cand(H11, 32'd10);
    wait_quiet();
    expect_eq("b2b_checked", bus.checked_count, 32'd4);
    expect_eq("b2b_hit_pulses", hit_cnt - h0, 1);
    expect_eq("b2b_hit_tag", bus.hit_tag, 32'd10);

    // Candidates queue while no targets are loaded
    do_reset();
    n0 = chk_cnt;
    for (int i = 0; i < 4; i++) push_cand(128'(8'hA0 + i), 32'(i + 1));
    expect_eq("fifo_full_cand_ready", bus.cand_ready, 1'b0);
    bus.cand_valid = 1'b1;
    bus.cand_hash  = 128'hA4;
    bus.cand_tag   = 32'd5;
    repeat (5) @(negedge clk);
    bus.cand_valid = 1'b0;
    expect_eq("no_targets_no_check", chk_cnt - n0, 0);
    expect_eq("no_targets_busy", bus.busy, 1'b0);
    chk_hash_q.delete();
    h0 = hit_cnt;
    load_tgt(128'hA1);
    wait_quiet();
    expect_eq("queued_checked", bus.checked_count, 32'd4);
    expect_eq("queued_chk_count", chk_hash_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (chk_hash_q.size() > i) expect_eq("queued_order", chk_hash_q[i], 128'(8'hA0 + i));
    expect_eq("queued_hit_pulses", hit_cnt - h0, 1);
    expect_eq("queued_hit_tag", bus.hit_tag, 32'd2);
    expect_eq("queued_hit_hash", bus.hit_hash, 128'hA1);

    // Target capacity
    do_reset();
    for (int i = 0; i < 64; i++) load_tgt({64'hC0DE, 64'(i)});
    wait_quiet();
    expect_eq("cap_targets", bus.targets_loaded, 7'd64);
    expect_eq("cap_load_ready", bus.load_ready, 1'b0);
    n0 = new_cnt;
    bus.load_valid = 1'b1;
    bus.load_hash  = H11;
    repeat (20) @(negedge clk);
    bus.load_valid = 1'b0;
    expect_eq("cap_no_65th", new_cnt - n0, 0);
    expect_eq("cap_targets_after", bus.targets_loaded, 7'd64);

    // Load takes priority over a queued candidate
    do_reset();
    load_tgt(H55);
    wait_quiet();
    ev_cyc_q.delete();
    ev_new_q.delete();
    h0 = hit_cnt;
    bus.load_valid = 1'b1;
    bus.load_hash  = H66;
    @(negedge clk);
    bus.load_hash  = H77;
    bus.cand_valid = 1'b1;
    bus.cand_hash  = H55;
    bus.cand_tag   = 32'd5;
    @(negedge clk);
    bus.cand_valid = 1'b0;
    n0 = 0;
    while (!bus.load_ready && n0 < 100) begin
      @(negedge clk);
      n0++;
    end
    expect_eq("prio_second_load_ready", bus.load_ready, 1'b1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    wait_quiet();
    expect_eq("prio_events", ev_new_q.size(), 3);
    if (ev_new_q.size() == 3) begin
      expect_eq("prio_ev0_new", ev_new_q[0], 1'b1);
      expect_eq("prio_ev1_new", ev_new_q[1], 1'b1);
      expect_eq("prio_ev2_chk", ev_new_q[2], 1'b0);
      expect_eq("prio_chk_after_drain", ev_cyc_q[2] - ev_cyc_q[1], 8);
    end
    expect_eq("prio_targets", bus.targets_loaded, 7'd3);
    expect_eq("prio_hit_pulses", hit_cnt - h0, 1);
    expect_eq("prio_hit_tag", bus.hit_tag, 32'd5);

    // Reset in the middle of a check
    do_reset();
    load_tgt(H55);
    wait_quiet();
    h0 = hit_cnt;
    push_cand(H55, 32'd3);
    wait_chk(t);
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    expect_eq("midrst_busy", bus.busy, 1'b0);
    expect_eq("midrst_hash", bus.hash, 128'd0);
    repeat (8) @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    expect_eq("midrst_no_hit", hit_cnt - h0, 0);
    expect_eq("midrst_checked", bus.checked_count, 32'd0);
    expect_eq("midrst_targets", bus.targets_loaded, 7'd0);

    // Checker timeout
    do_reset();
    load_tgt(H55);
    wait_quiet();
    rsp_en = 1'b0;
    push_cand(H55, 32'd4);
    wait_chk(t);
    repeat (16) @(negedge clk);
    expect_eq("tmo_not_yet", bus.error, 1'b0);
    @(negedge clk);
    expect_eq("tmo_error", bus.error, 1'b1);
    expect_eq("tmo_busy", bus.busy, 1'b1);
    expect_eq("tmo_cand_ready", bus.cand_ready, 1'b0);
    expect_eq("tmo_load_ready", bus.load_ready, 1'b0);
    n0 = new_cnt;
    bus.cand_valid = 1'b1;
    bus.load_valid = 1'b1;
    repeat (10) @(negedge clk);
    expect_eq("err_sticky", bus.error, 1'b1);
    expect_eq("err_cand_ready", bus.cand_ready, 1'b0);
    expect_eq("err_load_ready", bus.load_ready, 1'b0);
    expect_eq("err_no_new", new_cnt - n0, 0);
    expect_eq("err_checked", bus.checked_count, 32'd0);
    bus.cand_valid = 1'b0;
    bus.load_valid = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    rsp_en = 1'b1;
    expect_eq("err_rst_error", bus.error, 1'b0);
    expect_eq("err_rst_busy", bus.busy, 1'b0);
    expect_eq("err_rst_targets", bus.targets_loaded, 7'd0);
    expect_eq("err_rst_hash", bus.hash, 128'd0);
    expect_eq("err_rst_cand_ready", bus.cand_ready, 1'b1);
    expect_eq("err_rst_load_ready", bus.load_ready, 1'b1);

    expect_eq("never_both_requests", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/check_sequencer.md
CHECK_SEQUENCER -- requirements
Module: check_sequencer

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, candidate FIFO entries; MAX_TARGETS, default 64, checker target capacity; TIMEOUT, default 16, cycles allowed for a checker response.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- load_valid  in  1  target hash offered.
- load_hash  in  128  target hash.
- load_ready  out  1  target accepted when high with load_valid.
- cand_valid  in  1  candidate offered.
- cand_hash  in  128  candidate hash.
- cand_tag  in  32  candidate identifier.
- cand_ready  out  1  candidate accepted when high with cand_valid.
- newrdy  out  1  store request to checker.
- checkrdy  out  1  check request to checker.
- hash  out  128  hash presented to checker.
- resultrdy  in  1  checker completion.
- matchfound  in  1  checker result, valid while resultrdy high.
- hit_valid  out  1  one-cycle match report.
- hit_tag  out  32  tag of matching candidate.
- hit_hash  out  128  matching candidate hash.
- targets_loaded  out  7  targets stored, 0..64.
- checked_count  out  32  candidates checked.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky checker-timeout flag.

Function
REQ-003 SHALL implement states IDLE, ISSUE_NEW, WAIT_NEW, ISSUE_CHK, WAIT_CHK, DRAIN, ERROR.
REQ-004 load_ready SHALL be high only in IDLE with targets_loaded < MAX_TARGETS and error low.
REQ-005 IDLE with load_valid and load_ready: capture load_hash into hash; go to ISSUE_NEW. Load has priority over candidates.
REQ-006 IDLE, no accepted load, FIFO non-empty, targets_loaded > 0: pop head into hash and an internal tag register; go to ISSUE_CHK.
REQ-007 Candidates SHALL stay queued while targets_loaded = 0.
REQ-008 ISSUE_NEW and ISSUE_CHK SHALL last one cycle, driving newrdy or checkrdy high respectively, then go to WAIT_NEW or WAIT_CHK. newrdy and checkrdy SHALL never be high together.
REQ-009 hash SHALL stay unchanged from the ISSUE cycle until the state returns to IDLE.
REQ-010 WAIT_NEW on resultrdy=1: increment targets_loaded; go to DRAIN.
REQ-011 WAIT_CHK on resultrdy=1: increment checked_count, wrapping at 2^32. If matchfound=1, pulse hit_valid for the next cycle with hit_tag and hit_hash; both hold until the next hit. Go to DRAIN.
REQ-012 DRAIN SHALL wait for resultrdy=0, then go to IDLE. A multi-cycle resultrdy counts once.
REQ-013 WAIT_NEW and WAIT_CHK SHALL count cycles from entry. If TIMEOUT cycles pass without resultrdy, go to ERROR.
REQ-014 ERROR SHALL be terminal until reset:
- error=1, load_ready=0, cand_ready=0.
- FIFO contents frozen.
REQ-015 FIFO depth SHALL be FIFO_DEPTH, 160 bits wide (hash plus tag), first-in first-out.
REQ-016 cand_ready SHALL equal FIFO not full and error low. A pop in the same cycle SHALL NOT raise cand_ready while full.
REQ-017 A push and a pop in the same cycle SHALL both occur; occupancy is unchanged.
REQ-018 Latency with a checker whose resultrdy rises 4 cycles after checkrdy (T = ISSUE_CHK cycle):
- resultrdy seen in T+4.
- hit_valid high in T+5.
- IDLE re-entered at the cycle after resultrdy falls.

Reset
REQ-019 nrst low SHALL immediately force:
- state IDLE;
- FIFO empty;
- hash, hit_tag, hit_hash = 0;
- targets_loaded, checked_count = 0;
- newrdy, checkrdy, hit_valid, busy, error, load_ready = 0;
- cand_ready = 1 once nrst deasserts.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no count increment and no hit report.

Verification
REQ-021 Load targets 0x11..11 and 0x22..22, then candidate 0x22..22 with tag 7 -> targets_loaded=2, one hit_valid pulse, hit_tag=7, hit_hash=0x22..22, checked_count=1.
REQ-022 Candidate 0x33..33 with tag 9 after the REQ-021 loads -> no hit_valid, checked_count increments by 1, busy returns low.
REQ-023 Candidates offered with targets_loaded=0 -> cand_ready falls after 4 accepts, no checkrdy. Then load one target -> all 4 checked in order of tags.
REQ-024 Load 64 targets -> load_ready stays low; a 65th load_valid is never accepted; targets_loaded=64.
REQ-025 Checker held with resultrdy=0 after checkrdy -> error=1 after 16 cycles; cand_ready=0 and load_ready=0 until nrst pulse; all outputs at reset values afterwards.
REQ-026 load_valid and cand_valid both high in IDLE with a non-empty FIFO -> newrdy issued first; checkrdy follows only after DRAIN completes.
